delay_line_ctrl: RTL

Circular-buffer controller that sequences the dual-port sample RAM as a programmable delay line. Each sample strobe writes the incoming sample at the write pointer and reads back the sample written `offset` strobes earlier. A fill state machine blanks output until the delayed sample actually exists. Sits between the sample source (sine/ADC path) and the output stage of the signal generator.

---
 rtl/siggen_pkg.sv | 10 +
 rtl/ram.sv | 27 ++
 rtl/delay_line_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/siggen_pkg.sv
// Shared types for the signal-generator datapath blocks.
package siggen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } delay_state_t;

endpackage

// File: rtl/ram.sv
// Simple dual-port sample RAM, one write and one registered read port.
// A same-address read and write in one cycle returns the old contents.
module ram #(
    parameter int unsigned ADDRESS_WIDTH = 9,
    parameter int unsigned DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     rd_en,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/delay_line_ctrl.sv
// Circular-buffer controller running the sample RAM as a programmable delay line.
// Output is blanked until the delayed sample has actually been written.
module delay_line_ctrl
    import siggen_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 9,
    parameter int unsigned DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [ADDRESS_WIDTH-1:0] offset,
    input  logic [DATA_WIDTH-1:0]    din,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     dout_valid,
    output logic                     filled
);

    localparam logic [ADDRESS_WIDTH-1:0] PtrOne = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDRESS_WIDTH-1:0] wr_ptr_q, count_q, count_d, offset_q, rd_addr;
    logic [ADDRESS_WIDTH:0]   count_inc;
    logic [DATA_WIDTH-1:0]    din_q, ram_rdata;
    delay_state_t             state_q, state_d;
    logic                     blank_q, dout_valid_q, filled_q;
    logic                     ram_en, offset_gt_count, fill_done;

    // Reset wins over a concurrent strobe, so the RAM is never touched on a reset cycle.
    assign ram_en  = en & ~rst;
    assign rd_addr = wr_ptr_q - offset;

    assign count_inc       = {1'b0, count_q} + {{ADDRESS_WIDTH{1'b0}}, 1'b1};
    assign count_d         = (count_q == '1) ? count_q : count_q + PtrOne;
    assign offset_gt_count = offset > count_q;
    assign fill_done       = {1'b0, offset} <= count_inc;

    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                IDLE:    state_d = (offset == '0) ? RUN : FILL;
                FILL:    state_d = fill_done ? RUN : FILL;
                RUN:     state_d = offset_gt_count ? FILL : RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            count_q      <= '0;
            offset_q     <= '0;
            state_q      <= IDLE;
            blank_q      <= 1'b1;
            din_q        <= '0;
            dout_valid_q <= 1'b0;
            filled_q     <= 1'b0;
        end else begin
            dout_valid_q <= en;
            if (en) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
                count_q  <= count_d;
                offset_q <= offset;
                state_q  <= state_d;
                blank_q  <= offset_gt_count;
                din_q    <= din;
                filled_q <= (state_d == RUN);
            end
        end
    end

    // Zero delay reads the address being written, so serve it from the input register.
    always_comb begin
        if (blank_q) begin
            dout = '0;
        end else if (offset_q == '0) begin
            dout = din_q;
        end else begin
            dout = ram_rdata;
        end
    end

    assign dout_valid = dout_valid_q;
    assign filled     = filled_q;

    ram #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_ram (
        .clk    (clk),
        .wr_en  (ram_en),
        .wr_addr(wr_ptr_q),
        .wr_data(din),
        .rd_en  (ram_en),
        .rd_addr(rd_addr),
        .rd_data(ram_rdata)
    );

endmodule
